axis_pkt_csum: RTL
==================

AXIS_PKT_CSUM -- requirements
Module: axis_pkt_csum

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 32: data width of both stream ports; multiple of 8.
REQ-002 Parameter C_MAX_WORDS, default 8: packet buffer depth in words; power of 2, at least 2.
REQ-003 Parameter C_APPEND_CSUM, default 1: 1 appends an XOR checksum word to each output packet; 0 forwards the payload only.
REQ-004 AXIS_ACLK  in  1  the single clock for all logic.
REQ-005 AXIS_ARESETN  in  1  reset, asynchronous and active-low.
REQ-006 S_AXIS_TVALID/S_AXIS_TREADY  in/out  1/1  sink handshake.
REQ-007 S_AXIS_TDATA  in  C_AXIS_TDATA_WIDTH  sink data.
REQ-008 S_AXIS_TSTRB  in  C_AXIS_TDATA_WIDTH/8  sink byte qualifiers.
REQ-009 S_AXIS_TLAST  in  1  sink packet boundary.
REQ-010 M_AXIS_TVALID/M_AXIS_TREADY  out/in  1/1  source handshake.
REQ-011 M_AXIS_TDATA  out  C_AXIS_TDATA_WIDTH  source data.
REQ-012 M_AXIS_TSTRB  out  C_AXIS_TDATA_WIDTH/8  all ones, constant.
REQ-013 M_AXIS_TLAST  out  1  marks the last output beat.
REQ-014 pkt_count  out  16  count of packets fully sent; wraps from 0xFFFF to 0.
REQ-015 csum_nonzero  out  1  checksum of the last completed packet is non-zero.
REQ-016 truncated  out  1  the last completed packet exceeded C_MAX_WORDS.

Function
REQ-017 The FSM SHALL have three states: RECV, DRAIN and SEND.
REQ-018 In RECV, S_AXIS_TREADY SHALL be 1; in DRAIN, S_AXIS_TREADY SHALL be 1; in SEND, S_AXIS_TREADY SHALL be 0.
REQ-019 An accepted RECV beat SHALL be written to buf[wr_ptr] with each byte lane whose TSTRB bit is 0 written as 0x00; the checksum SHALL be updated as checksum ^= masked word; wr_ptr SHALL increment.
REQ-020 An accepted RECV beat with TLAST=1 SHALL cause the transition RECV->SEND.
REQ-021 An accepted RECV beat with TLAST=0 and wr_ptr==C_MAX_WORDS-1 SHALL be stored, then cause the transition RECV->DRAIN.
REQ-022 DRAIN SHALL discard accepted beats without touching the buffer or the checksum; an accepted beat with TLAST=1 SHALL cause DRAIN->SEND.
REQ-023 On a packet entering SEND via DRAIN, the truncated flag SHALL be set.
REQ-024 The word count SHALL be clogb2(C_MAX_WORDS+1) bits wide and SHALL range from 1 to C_MAX_WORDS.
REQ-025 In SEND, M_AXIS_TVALID SHALL be 1 from the cycle after the terminating sink beat is accepted.
REQ-026 SEND SHALL output buf[0..count-1] in order, followed by the checksum word when C_APPEND_CSUM=1.
REQ-027 M_AXIS_TLAST SHALL be 1 only on the final beat.
REQ-028 While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA and M_AXIS_TLAST SHALL hold stable.
REQ-029 Acceptance of the final beat SHALL return the FSM to RECV with wr_ptr, rd_ptr and checksum cleared.
REQ-030 Acceptance of the final beat SHALL increment pkt_count and update csum_nonzero and truncated in the same cycle.
REQ-031 When SEND is left, M_AXIS_TVALID SHALL drop in the next cycle.
REQ-032 Back-to-back operation SHALL apply: S_AXIS_TREADY SHALL be 1 in the cycle after the last source beat is accepted.
REQ-033 A TLAST arriving on the C_MAX_WORDS-th beat SHALL count as a normal packet, not a truncated one.

Reset
REQ-034 Asserting AXIS_ARESETN low SHALL immediately and asynchronously force: state RECV; pointers, checksum, pkt_count, csum_nonzero and truncated to 0; M_AXIS_TVALID and M_AXIS_TLAST to 0; M_AXIS_TDATA to 0.
REQ-035 The buffer contents are undefined after reset.
REQ-036 Reset asserted mid-packet SHALL discard that packet with no partial output.
REQ-037 S_AXIS_TREADY SHALL be 1 in the first cycle after reset is released.

Structure
REQ-038 Package axis_pkt_pkg SHALL hold the state encoding and the clogb2 function.
REQ-039 Storage SHALL be a sub-module, axis_pkt_buffer: a simple dual-port register array with one write port and one read port, C_MAX_WORDS x C_AXIS_TDATA_WIDTH.

Verification (C_AXIS_TDATA_WIDTH=32, C_MAX_WORDS=8, C_APPEND_CSUM=1)
REQ-040 Packet 0x1,0x2,0x4,0x8 with TLAST on the 4th beat, M_AXIS_TREADY=1 -> output 0x1,0x2,0x4,0x8,0xF with TLAST on the 5th beat; csum_nonzero=1, pkt_count=1.
REQ-041 Same packet with M_AXIS_TREADY alternating 0/1 -> identical output sequence; TDATA and TLAST stable across every stall; S_AXIS_TREADY=0 throughout SEND.
REQ-042 Ten words 0x1..0xA with TLAST on the 10th -> all ten beats accepted; output 0x1..0x8,0x8 with TLAST on the 9th beat; truncated=1.
REQ-043 Single word 0xAABBCCDD with TSTRB=0b0101 -> output 0x00BB00DD,0x00BB00DD.
REQ-044 Packet 0x5,0x5 -> output 0x5,0x5,0x0; csum_nonzero=0; the next packet is accepted the cycle after the final beat.
REQ-045 AXIS_ARESETN pulsed low after 2 of 5 source beats -> M_AXIS_TVALID=0 immediately; pkt_count=0; S_AXIS_TREADY=1 in the first cycle after release.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Purpose: shared types and helpers for the packet checksum block (FSM encoding, clogb2).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_pkt_pkg;

    // RECV  : store beats into the buffer and fold them into the running XOR
    // DRAIN : buffer is full; swallow the rest of the packet until TLAST
    // SEND  : replay the stored words (plus the checksum word) to the source
    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // Number of bits needed to address 'depth' distinct values (0..depth-1).
    // clogb2(1)=0, clogb2(8)=3, clogb2(9)=4.
    function automatic int clogb2(input int depth);
        int v;
        int r;
        v = depth - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_pkt_csum_if.sv
// Purpose: one AXI4-Stream link (valid/ready, data, byte strobes, last).
// Latency: n/a (wires only).
// Backpressure: tready from the slave side stalls the master side.
// Ports: master drives tvalid/tdata/tstrb/tlast and samples tready; slave is the mirror.
interface axis_pkt_csum_if #(
    parameter int C_AXIS_TDATA_WIDTH = 32
);
    logic                              tvalid;
    logic                              tready;
    logic [C_AXIS_TDATA_WIDTH-1:0]     tdata;
    logic [C_AXIS_TDATA_WIDTH/8-1:0]   tstrb;
    logic                              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_pkt_buffer.sv
// Purpose: packet word store, simple dual-port register array (1 write, 1 read port).
// Latency: write lands on the clock edge; read is combinational from the array.
// Backpressure: none; the caller qualifies wr_en.
// Ports: AXIS_ACLK clock; wr_en/wr_addr/wr_dat write port; rd_addr -> rd_dat read port.
module axis_pkt_buffer
    import axis_pkt_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_MAX_WORDS        = 8,
    parameter int AW                 = clogb2(C_MAX_WORDS)
) (
    input  logic                          AXIS_ACLK,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]                 rd_addr,
    output logic [C_AXIS_TDATA_WIDTH-1:0] rd_dat
);

    // No reset on the array: contents are don't-care until written, and the
    // control path never reads a word of the current packet before writing it.
    logic [C_AXIS_TDATA_WIDTH-1:0] mem [C_MAX_WORDS];

    always_ff @(posedge AXIS_ACLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Combinational read so a single-word packet written on the terminating
    // edge is visible on the very next cycle without a bypass path.
    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_csum.sv
// Purpose: store-and-forward AXIS packet buffer that appends an XOR checksum word.
// Latency: first output beat is valid the cycle after the sink TLAST beat is accepted.
// Backpressure: sink is held off (tready=0) for the whole replay; source stalls hold data/last stable.
// Ports: AXIS_ACLK/AXIS_ARESETN clock and async active-low reset; s_axis packet sink;
//        m_axis packet source (tstrb all ones); pkt_count packets fully sent (wraps);
//        csum_nonzero / truncated describe the last completed packet.
module axis_pkt_csum
    import axis_pkt_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_MAX_WORDS        = 8,
    parameter int C_APPEND_CSUM      = 1
) (
    input  logic                 AXIS_ACLK,
    input  logic                 AXIS_ARESETN,
    axis_pkt_csum_if.slave       s_axis,
    axis_pkt_csum_if.master      m_axis,
    output logic [15:0]          pkt_count,
    output logic                 csum_nonzero,
    output logic                 truncated
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int SW = C_AXIS_TDATA_WIDTH / 8;
    // Word count must hold C_MAX_WORDS itself, hence the +1.
    localparam int CW = clogb2(C_MAX_WORDS + 1);
    localparam int AW = clogb2(C_MAX_WORDS);

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   wr_ptr;       // words stored; doubles as packet length in SEND
    logic [CW-1:0]   rd_ptr;       // next output beat index
    logic [DW-1:0]   csum;         // running XOR of stored (masked) words
    logic            trunc_pend;   // current packet overflowed the buffer

    logic            s_rdy;
    logic            m_vld;
    logic            s_acc;
    logic            m_acc;
    logic [DW-1:0]   s_masked_dat;
    logic [DW-1:0]   buf_rd_dat;
    logic            buf_wr_en;
    logic [CW-1:0]   last_idx;
    logic            last_beat;
    logic            is_csum_beat;

    // ------------------------------------------------------------------
    // Sink byte masking: lanes with a clear strobe are stored as 0x00 so
    // that the stored word and the checksum agree on what was received.
    // ------------------------------------------------------------------
    always_comb begin
        s_masked_dat = '0;
        for (int i = 0; i < SW; i++) begin
            if (s_axis.tstrb[i]) begin
                s_masked_dat[8*i +: 8] = s_axis.tdata[8*i +: 8];
            end
        end
    end

    assign s_acc = s_axis.tvalid && s_rdy;
    assign m_acc = m_vld && m_axis.tready;

    // Index of the final output beat: the checksum slot sits right after the
    // last payload word (index == wr_ptr) when appending is enabled.
    assign last_idx     = (C_APPEND_CSUM != 0) ? wr_ptr : (wr_ptr - CW'(1));
    assign last_beat    = (rd_ptr == last_idx);
    assign is_csum_beat = (C_APPEND_CSUM != 0) && (rd_ptr == wr_ptr);

    assign buf_wr_en = (state == ST_RECV) && s_acc;

    axis_pkt_buffer #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_MAX_WORDS        (C_MAX_WORDS),
        .AW                 (AW)
    ) u_buf (
        .AXIS_ACLK (AXIS_ACLK),
        .wr_en     (buf_wr_en),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_dat    (s_masked_dat),
        .rd_addr   (rd_ptr[AW-1:0]),
        .rd_dat    (buf_rd_dat)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state <= ST_RECV;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        s_rdy     = 1'b0;
        m_vld     = 1'b0;
        case (state)
            ST_RECV: begin
                s_rdy = 1'b1;
                if (s_acc) begin
                    // TLAST wins over the full check so an exactly-full
                    // packet is treated as a normal one.
                    if (s_axis.tlast) begin
                        state_nxt = ST_SEND;
                    end else if (wr_ptr == CW'(C_MAX_WORDS - 1)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                s_rdy = 1'b1;
                if (s_acc && s_axis.tlast) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                m_vld = 1'b1;
                if (m_acc && last_beat) begin
                    state_nxt = ST_RECV;
                end
            end
            default: begin
                state_nxt = ST_RECV;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pointers, checksum, status
    // ------------------------------------------------------------------
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            csum         <= '0;
            trunc_pend   <= 1'b0;
            pkt_count    <= '0;
            csum_nonzero <= 1'b0;
            truncated    <= 1'b0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (s_acc) begin
                        wr_ptr <= wr_ptr + CW'(1);
                        csum   <= csum ^ s_masked_dat;
                        if (!s_axis.tlast && (wr_ptr == CW'(C_MAX_WORDS - 1))) begin
                            trunc_pend <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (m_acc) begin
                        if (last_beat) begin
                            rd_ptr       <= '0;
                            wr_ptr       <= '0;
                            csum         <= '0;
                            trunc_pend   <= 1'b0;
                            pkt_count    <= pkt_count + 16'd1;
                            csum_nonzero <= |csum;
                            truncated    <= trunc_pend;
                        end else begin
                            rd_ptr <= rd_ptr + CW'(1);
                        end
                    end
                end
                default: begin
                    // DRAIN discards beats: buffer, checksum and count untouched.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stream outputs. Everything here is decoded from registers only, so
    // data and last cannot move while the source is stalled, and reset
    // forces valid/last/data low without waiting for a clock.
    // ------------------------------------------------------------------
    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_vld;
    assign m_axis.tdata  = !m_vld       ? '0 :
                           is_csum_beat ? csum : buf_rd_dat;
    assign m_axis.tlast  = m_vld && last_beat;
    assign m_axis.tstrb  = '1;

endmodule
